work_loader: RTL and testbench

- Upstream feeder for the double-SHA256 nonce-search core.
- Receives a job frame as a byte stream with a valid/ready handshake, then unpacks it into the core's input fields: midstate, 64-byte block, nonce base and target.
- Fields are assembled in shadow registers and committed atomically. The core's inputs stay stable for the whole search and change only when a new job is issued.

---
 rtl/work_loader_if.sv | 33 +++
 rtl/work_loader.sv | 203 ++++++++++++++++++++
 tb/tb_work_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/work_loader_if.sv
// work_loader_if
//   Byte-stream input and job-field output bundle of the work loader.
//   master : upstream feeder / consumer side (drives the byte stream)
//   slave  : the loader itself
//   Signals:
//     in_byte_valid/in_byte/in_byte_ready : byte stream handshake
//     out_valid                           : one-cycle new-job pulse
//     out_data/out_state/out_nonce_base/out_target : committed job fields
//     busy, frame_err                     : frame status
interface work_loader_if;
  logic                 in_byte_valid;
  logic [7:0]           in_byte;
  logic                 in_byte_ready;
  logic                 out_valid;
  logic [63:0][7:0]     out_data;
  logic [7:0][31:0]     out_state;
  logic [31:0]          out_nonce_base;
  logic [31:0][7:0]     out_target;
  logic                 busy;
  logic                 frame_err;

  modport master (
    output in_byte_valid, in_byte,
    input  in_byte_ready, out_valid, out_data, out_state, out_nonce_base,
           out_target, busy, frame_err
  );

  modport slave (
    input  in_byte_valid, in_byte,
    output in_byte_ready, out_valid, out_data, out_state, out_nonce_base,
           out_target, busy, frame_err
  );
endinterface

// File: rtl/work_loader.sv
// work_loader
//   Feeds the double-SHA256 nonce-search core. Collects a sync-prefixed job
//   frame from a byte stream into a shadow buffer and commits all job fields
//   atomically, pulsing out_valid in the cycle the new values appear.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : work_loader_if.slave (byte stream in, job fields/status out)
//   Optional feature: define WORK_LOADER_CHECKSUM_EN to require a trailing
//   XOR checksum byte over the 132 payload bytes before committing.
//
//   state   | meaning
//   IDLE    | hunting for SYNC_BYTE, other bytes dropped
//   LOAD    | writing payload bytes into the shadow buffer
//   CHECK   | waiting for checksum byte (checksum build only)
//   ISSUE   | one cycle: new job visible, out_valid high, not ready
module work_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic          clk,
  input logic          rst,
  work_loader_if.slave bus
);
  localparam int PAYLOAD_LEN = 132;
  localparam int TO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

`ifdef WORK_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_CHECK} state_e;
  logic [7:0] csum_q, csum_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE} state_e;
`endif

  state_e            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        shadow_q [PAYLOAD_LEN];
  logic [7:0]        shadow_d [PAYLOAD_LEN];
  logic              frame_err_q, err_d;
  logic              commit;
  logic              accept, timed_out, last_payload;

  logic [63:0][7:0]  out_data_q, data_unpk;
  logic [7:0][31:0]  out_state_q, state_unpk;
  logic [31:0]       out_nonce_q, nonce_unpk;
  logic [31:0][7:0]  out_target_q, target_unpk;

  assign accept       = bus.in_byte_valid && (state_q != S_ISSUE);
  assign last_payload = (idx_q == 8'(PAYLOAD_LEN - 1));
  // Idle count reaches TIMEOUT_CYCLES on this edge.
  assign timed_out    = TO_EN && !accept && (to_cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (accept && bus.in_byte == SYNC_BYTE) state_d = S_LOAD;
      S_LOAD: begin
        if (accept && last_payload) begin
`ifdef WORK_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_ISSUE;
          commit  = 1'b1;
`endif
        end else if (timed_out) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
`ifdef WORK_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (bus.in_byte == csum_q) begin
            state_d = S_ISSUE;
            commit  = 1'b1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else if (timed_out) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
`endif
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.in_byte_ready = (state_q != S_ISSUE);
    bus.busy          = (state_q != S_IDLE);
    bus.out_valid     = (state_q == S_ISSUE);
  end

  // Payload index, idle counter, shadow buffer and checksum
  always_comb begin
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    shadow_d = shadow_q;
`ifdef WORK_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          shadow_d[idx_q] = bus.in_byte;
          idx_d           = idx_q + 8'd1;
          to_cnt_d        = '0;
`ifdef WORK_LOADER_CHECKSUM_EN
          csum_d          = csum_q ^ bus.in_byte;
`endif
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
`ifdef WORK_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept)     to_cnt_d = '0;
        else if (TO_EN) to_cnt_d = to_cnt_q + TO_W'(1);
      end
`endif
      default: begin
        idx_d    = '0;
        to_cnt_d = '0;
`ifdef WORK_LOADER_CHECKSUM_EN
        csum_d   = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      to_cnt_q <= '0;
      shadow_q <= '{default: '0};
`ifdef WORK_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      shadow_q <= shadow_d;
`ifdef WORK_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Unpack from shadow_d so the final payload byte, written on the same edge
  // as the commit, is already included.
  for (genvar i = 0; i < 8; i++) begin : g_state
    assign state_unpk[i] = {shadow_d[4*i], shadow_d[4*i+1],
                            shadow_d[4*i+2], shadow_d[4*i+3]};
  end
  for (genvar k = 0; k < 64; k++) begin : g_data
    assign data_unpk[k] = shadow_d[32+k];
  end
  for (genvar k = 0; k < 32; k++) begin : g_target
    assign target_unpk[k] = shadow_d[100+k];
  end
  assign nonce_unpk = {shadow_d[99], shadow_d[98], shadow_d[97], shadow_d[96]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_state_q  <= '0;
      out_nonce_q  <= '0;
      out_target_q <= '0;
    end else if (commit) begin
      out_data_q   <= data_unpk;
      out_state_q  <= state_unpk;
      out_nonce_q  <= nonce_unpk;
      out_target_q <= target_unpk;
    end
  end

  assign bus.out_data       = out_data_q;
  assign bus.out_state      = out_state_q;
  assign bus.out_nonce_base = out_nonce_q;
  assign bus.out_target     = out_target_q;
  assign bus.frame_err      = frame_err_q;
endmodule

// File: tb/tb_work_loader.sv
module tb_work_loader;
  localparam int TO = 16;
`ifdef WORK_LOADER_CHECKSUM_EN
  localparam int FRAME_LEN = 134;
`else
  localparam int FRAME_LEN = 133;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  work_loader_if bus();
  work_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0, failures = 0;
  int ov_cnt = 0, fe_cnt = 0, rdy_viol = 0;

  logic [7:0]       pl [132];
  logic [7:0][31:0] exp_state;
  logic [63:0][7:0] exp_data;
  logic [31:0]      exp_nonce;
  logic [31:0][7:0] exp_target;

  // Pulse counters and ready rule: ready is low exactly when a job is issued.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) ov_cnt++;
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (rst === 1'b0 && bus.in_byte_ready === bus.out_valid) rdy_viol++;
  end

  task automatic model_commit();
    int unsigned w;
    for (int i = 0; i < 8; i++) begin
      w = 0;
      for (int j = 0; j < 4; j++) w = w * 256 + pl[4*i+j];
      exp_state[i] = w;
    end
    for (int k = 0; k < 64; k++) exp_data[k] = pl[32+k];
    w = 0;
    for (int j = 3; j >= 0; j--) w = w * 256 + pl[96+j];
    exp_nonce = w;
    for (int k = 0; k < 32; k++) exp_target[k] = pl[100+k];
  endtask

  task automatic model_clear();
    exp_state = '0; exp_data = '0; exp_nonce = '0; exp_target = '0;
  endtask

  task automatic rand_payload(input bool_sync_heavy);
    for (int k = 0; k < 132; k++)
      pl[k] = (bool_sync_heavy && $urandom_range(3) == 0) ? 8'hA5 : 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      bus.in_byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_byte_valid = 1'b1;
    bus.in_byte = b;
    n = 0;
    while (bus.in_byte_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL send_ready_wait actual ready=%b required ready=1", bus.in_byte_ready);
    end
    @(posedge clk); #1;
    bus.in_byte_valid = 1'b0;
  endtask

  // Frame byte n: 0 = sync, 1..132 = payload, 133 = checksum.
  task automatic send_range(input int first, input int last, input int gap, input bit bad_ck);
    logic [7:0] ck, b;
    ck = 8'h00;
    for (int k = 0; k < 132; k++) ck = ck ^ pl[k];
    if (bad_ck) ck = ck ^ 8'h01;
    for (int n = first; n <= last; n++) begin
      if (n == 0) b = 8'hA5;
      else if (n <= 132) b = pl[n-1];
      else b = ck;
      send_byte(b, (n == first) ? 0 : gap);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_byte_valid = 1'b0;
    bus.in_byte = 8'h00;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.frame_err, bus.busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_status actual valid/err/busy=%b required 000",
               {bus.out_valid, bus.frame_err, bus.busy});
    end
    checks++;
    if ({bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !== '0) begin
      failures++;
      $display("FAIL reset_fields actual state0=%h nonce=%h required all zero",
               bus.out_state[0], bus.out_nonce_base);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready actual %b required 1", bus.in_byte_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] iv [8];
    int ov0;
    iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) pl[4*i+j] = 8'(iv[i] >> (24 - 8*j));
    for (int k = 0; k < 64; k++) pl[32+k] = 8'(k);
    pl[96] = 8'h78; pl[97] = 8'h56; pl[98] = 8'h34; pl[99] = 8'h12;
    for (int k = 0; k < 32; k++) pl[100+k] = 8'h00;
    ov0 = ov_cnt;
    send_range(0, FRAME_LEN - 1, 0, 1'b0);
    model_commit();
    checks++;
    if ({bus.out_valid, bus.in_byte_ready} !== 2'b10) begin
      failures++;
      $display("FAIL basic_issue actual valid/ready=%b required 10", {bus.out_valid, bus.in_byte_ready});
    end
    checks++;
    if (bus.out_state[0] !== 32'h6a09e667 || bus.out_data[5] !== 8'h05 ||
        bus.out_nonce_base !== 32'h12345678) begin
      failures++;
      $display("FAIL basic_spot actual state0=%h data5=%h nonce=%h required 6a09e667 05 12345678",
               bus.out_state[0], bus.out_data[5], bus.out_nonce_base);
    end
    checks++;
    if ({bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !==
        {exp_state, exp_data, exp_nonce, exp_target}) begin
      failures++;
      $display("FAIL basic_fields actual state3=%h target0=%h required state3=%h target0=%h",
               bus.out_state[3], bus.out_target[0], exp_state[3], exp_target[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_byte_ready !== 1'b1 || ov_cnt - ov0 != 1) begin
      failures++;
      $display("FAIL basic_pulse actual valid=%b ready=%b pulses=%0d required 0 1 1",
               bus.out_valid, bus.in_byte_ready, ov_cnt - ov0);
    end
  endtask

  task automatic test_garbage();
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h3C, 0);
    rand_payload(1'b0);
    send_range(0, FRAME_LEN - 1, 0, 1'b0);
    model_commit();
    checks++;
    if (bus.out_valid !== 1'b1 ||
        {bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !==
        {exp_state, exp_data, exp_nonce, exp_target}) begin
      failures++;
      $display("FAIL garbage_commit actual valid=%b nonce=%h required 1 nonce=%h",
               bus.out_valid, bus.out_nonce_base, exp_nonce);
    end
    @(posedge clk); #1;
    checks++;
    if (fe_cnt != fe0) begin
      failures++;
      $display("FAIL garbage_no_err actual err_pulses=%0d required 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_toggle();
    int ov0;
    ov0 = ov_cnt;
    rand_payload(1'b0);
    send_range(0, FRAME_LEN - 1, 1, 1'b0);
    model_commit();
    checks++;
    if (bus.out_valid !== 1'b1 ||
        {bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !==
        {exp_state, exp_data, exp_nonce, exp_target}) begin
      failures++;
      $display("FAIL toggle_commit actual valid=%b state0=%h required 1 state0=%h",
               bus.out_valid, bus.out_state[0], exp_state[0]);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ov_cnt - ov0 != 1) begin
      failures++;
      $display("FAIL toggle_pulses actual %0d required 1", ov_cnt - ov0);
    end
  endtask

  task automatic test_timeout();
    int n, ov0, fe0;
    ov0 = ov_cnt; fe0 = fe_cnt;
    rand_payload(1'b0);
    send_range(0, 49, 0, 1'b0);
    n = 1;
    while (n <= 40) begin
      @(posedge clk); #1;
      if (bus.frame_err === 1'b1) break;
      n++;
    end
    checks++;
    if (n != TO) begin
      failures++;
      $display("FAIL timeout_cycles actual %0d required %0d", n, TO);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
        {bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !==
        {exp_state, exp_data, exp_nonce, exp_target}) begin
      failures++;
      $display("FAIL timeout_hold actual busy=%b valid=%b nonce=%h required 0 0 nonce=%h",
               bus.busy, bus.out_valid, bus.out_nonce_base, exp_nonce);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.frame_err !== 1'b0 || fe_cnt - fe0 != 1 || ov_cnt != ov0) begin
      failures++;
      $display("FAIL timeout_pulse actual err=%b err_pulses=%0d valid_pulses=%0d required 0 1 0",
               bus.frame_err, fe_cnt - fe0, ov_cnt - ov0);
    end
    rand_payload(1'b0);
    send_range(0, FRAME_LEN - 1, 0, 1'b0);
    model_commit();
    checks++;
    if (bus.out_valid !== 1'b1 ||
        {bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !==
        {exp_state, exp_data, exp_nonce, exp_target}) begin
      failures++;
      $display("FAIL timeout_recover actual valid=%b nonce=%h required 1 nonce=%h",
               bus.out_valid, bus.out_nonce_base, exp_nonce);
    end
  endtask

  task automatic test_reset_mid();
    rand_payload(1'b0);
    send_range(0, 69, 0, 1'b0);
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if ({bus.out_valid, bus.frame_err, bus.busy} !== 3'b000 ||
        {bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !== '0) begin
      failures++;
      $display("FAIL midreset_zero actual valid/err/busy=%b nonce=%h required 000 nonce=0",
               {bus.out_valid, bus.frame_err, bus.busy}, bus.out_nonce_base);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rand_payload(1'b0);
    send_range(0, FRAME_LEN - 1, 0, 1'b0);
    model_commit();
    checks++;
    if (bus.out_valid !== 1'b1 ||
        {bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !==
        {exp_state, exp_data, exp_nonce, exp_target}) begin
      failures++;
      $display("FAIL midreset_reload actual valid=%b state7=%h required 1 state7=%h",
               bus.out_valid, bus.out_state[7], exp_state[7]);
    end
  endtask

  task automatic test_back_to_back();
    rand_payload(1'b1);
    send_range(0, FRAME_LEN - 1, 0, 1'b0);
    model_commit();
    checks++;
    if (bus.out_valid !== 1'b1 ||
        {bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !==
        {exp_state, exp_data, exp_nonce, exp_target}) begin
      failures++;
      $display("FAIL b2b_first actual valid=%b data0=%h required 1 data0=%h",
               bus.out_valid, bus.out_data[0], exp_data[0]);
    end
    rand_payload(1'b1);
    send_range(0, 60, 0, 1'b0);
    checks++;
    if (bus.busy !== 1'b1 ||
        {bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !==
        {exp_state, exp_data, exp_nonce, exp_target}) begin
      failures++;
      $display("FAIL b2b_hold actual busy=%b data0=%h required 1 data0=%h",
               bus.busy, bus.out_data[0], exp_data[0]);
    end
    send_range(61, FRAME_LEN - 1, 0, 1'b0);
    model_commit();
    checks++;
    if (bus.out_valid !== 1'b1 ||
        {bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !==
        {exp_state, exp_data, exp_nonce, exp_target}) begin
      failures++;
      $display("FAIL b2b_second actual valid=%b target31=%h required 1 target31=%h",
               bus.out_valid, bus.out_target[31], exp_target[31]);
    end
    @(posedge clk); #1;
  endtask

`ifdef WORK_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    int ov0;
    ov0 = ov_cnt;
    rand_payload(1'b0);
    send_range(0, FRAME_LEN - 1, 0, 1'b1);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        {bus.out_state, bus.out_data, bus.out_nonce_base, bus.out_target} !==
        {exp_state, exp_data, exp_nonce, exp_target}) begin
      failures++;
      $display("FAIL cksum_bad actual err=%b valid=%b busy=%b nonce=%h required 1 0 0 nonce=%h",
               bus.frame_err, bus.out_valid, bus.busy, bus.out_nonce_base, exp_nonce);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.frame_err !== 1'b0 || ov_cnt != ov0) begin
      failures++;
      $display("FAIL cksum_bad_pulse actual err=%b valid_pulses=%0d required 0 0",
               bus.frame_err, ov_cnt - ov0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_garbage();
    test_toggle();
    test_timeout();
`ifdef WORK_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdy_viol != 0) begin
      failures++;
      $display("FAIL ready_rule actual violations=%0d required 0", rdy_viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
